pmu_ahb_master: RTL and testbench

- Upstream AHB-Lite single-transfer master that drives the PMU AHB slave.
- Converts a valid/ready request channel (from a debug or config controller) into one NONSEQ word transfer at a time.
- Returns read data and error status on a valid/ready response channel.
- Adds address-window/alignment decode errors and a bus-stall timeout, so a hung slave cannot lock the requester.

---
 rtl/pmu_ahb_master.sv | 167 ++++++++++++++++
 tb/tb_pmu_ahb_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_ahb_master.sv
// pmu_ahb_master
// AHB-Lite master for the PMU slave. It issues one NONSEQ word transfer at a
// time and has only one transfer outstanding. Requests that fall outside the
// PMU window or are not word-aligned are answered locally without touching the
// bus. A stall timeout keeps a hung slave from blocking the requester.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | ready for a request; the bus is idle
// S_ADDR | address phase, NONSEQ is on the bus until hready_i is sampled high
// S_DATA | data phase, waits for the first hready_i=1 to collect the response
// S_RESP | response is held on rsp_* until rsp_ready_i
module pmu_ahb_master #(
    parameter int unsigned          REG_WIDTH      = 32,
    parameter logic [REG_WIDTH-1:0] ADDR_BASE      = 32'h80100000,
    parameter logic [REG_WIDTH-1:0] ADDR_MASK      = 32'hfff,
    parameter int unsigned          TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [REG_WIDTH-1:0] req_addr_i,
    input  logic [REG_WIDTH-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [REG_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 hsel_o,
    output logic [REG_WIDTH-1:0] haddr_o,
    output logic                 hwrite_o,
    output logic [1:0]           htrans_o,
    output logic [2:0]           hsize_o,
    output logic [2:0]           hburst_o,
    output logic [3:0]           hprot_o,
    output logic                 hmastlock_o,
    output logic [REG_WIDTH-1:0] hwdata_o,
    input  logic                 hready_i,
    input  logic [1:0]           hresp_i,
    input  logic [REG_WIDTH-1:0] hrdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    // The stall timer is a down-counter reloaded on every phase entry; the
    // stall that finds it at 1 is the TIMEOUT_CYCLES-th one of the phase.
    localparam int unsigned   TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t                 r_state;
    logic                   r_write;
    logic [REG_WIDTH-1:0]   r_wdata;
    logic [TW-1:0]          r_tmo_cnt;

    logic                   w_dec_ok;
    logic                   w_tmo_hit;
    logic                   w_slv_err;
    logic [REG_WIDTH-1:0]   w_rdata;

    // Request decode, timer terminal count and data-phase response selection
    assign w_dec_ok    = ((req_addr_i & ~ADDR_MASK) == ADDR_BASE) && (req_addr_i[1:0] == 2'b00);
    assign w_tmo_hit   = TMO_EN && (r_tmo_cnt == TW'(1));
    assign w_slv_err   = (hresp_i == 2'b01);
    assign w_rdata     = ((hresp_i == 2'b00) && !r_write) ? hrdata_i : '0;

    // Handshake ready is decoded from state only, so req_* never reaches h*
    assign req_ready_o = (r_state == S_IDLE);

    assign hsize_o     = 3'b010;
    assign hburst_o    = 3'b000;
    assign hprot_o     = 4'b0011;
    assign hmastlock_o = 1'b0;

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_tmo_cnt     <= '0;
            hsel_o        <= 1'b0;
            htrans_o      <= 2'b00;
            hwrite_o      <= 1'b0;
            haddr_o       <= '0;
            hwdata_o      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_write <= req_write_i;
                        r_wdata <= req_wdata_i;
                        if (!w_dec_ok) begin
                            r_state       <= S_RESP;
                            rsp_valid_o   <= 1'b1;
                            rsp_err_o     <= 1'b1;
                            rsp_timeout_o <= 1'b0;
                            rsp_rdata_o   <= '0;
                        end else begin
                            r_state   <= S_ADDR;
                            r_tmo_cnt <= TMO_LOAD;
                            hsel_o    <= 1'b1;
                            htrans_o  <= 2'b10;
                            haddr_o   <= req_addr_i;
                            hwrite_o  <= req_write_i;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready_i) begin
                        r_state   <= S_DATA;
                        r_tmo_cnt <= TMO_LOAD;
                        hsel_o    <= 1'b0;
                        htrans_o  <= 2'b00;
                        hwdata_o  <= r_wdata;
                    end else if (w_tmo_hit) begin
                        r_state       <= S_RESP;
                        hsel_o        <= 1'b0;
                        htrans_o      <= 2'b00;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                    end else if (TMO_EN) begin
                        r_tmo_cnt <= r_tmo_cnt - TW'(1);
                    end
                end
                S_DATA: begin
                    if (hready_i) begin
                        r_state       <= S_RESP;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= w_slv_err;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= w_rdata;
                    end else if (w_tmo_hit) begin
                        r_state       <= S_RESP;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                    end else if (TMO_EN) begin
                        r_tmo_cnt <= r_tmo_cnt - TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state       <= S_IDLE;
                        rsp_valid_o   <= 1'b0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmu_ahb_master.sv
// Directed and random bench for pmu_ahb_master; the bench plays the AHB slave
// and keeps its own reference copy of the PMU register space.
module tb_pmu_ahb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        hsel_o;
    logic [31:0] haddr_o;
    logic        hwrite_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic        hmastlock_o;
    logic [31:0] hwdata_o;
    logic        hready_i;
    logic [1:0]  hresp_i;
    logic [31:0] hrdata_i;

    logic [31:0] ref_mem   [0:1023];
    logic [31:0] slave_mem [0:1023];
    int          n_vec;
    int          n_miscmp;

    pmu_ahb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .hsel_o        (hsel_o),
        .haddr_o       (haddr_o),
        .hwrite_o      (hwrite_o),
        .htrans_o      (htrans_o),
        .hsize_o       (hsize_o),
        .hburst_o      (hburst_o),
        .hprot_o       (hprot_o),
        .hmastlock_o   (hmastlock_o),
        .hwdata_o      (hwdata_o),
        .hready_i      (hready_i),
        .hresp_i       (hresp_i),
        .hrdata_i      (hrdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One request from handshake to response handshake; waits = data-phase
    // stall cycles, slv_err = two-cycle ERROR, bp = cycles of rsp_ready_i low.
    task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic slv_err, input int bp);
        logic        exp_dec;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [9:0]  idx;
        logic [9:0]  slv_idx;
        exp_dec   = ((addr & ~32'hfff) != 32'h80100000) || (addr[1:0] != 2'b00);
        idx       = addr[11:2];
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
        step();
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(negedge clk_i);
        chk({tag, ":acc_ready"}, 32'(req_ready_o), 1);
        step();
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom_range(0, 1));
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        if (!exp_dec) begin
            @(negedge clk_i);
            chk({tag, ":a_htrans"}, 32'(htrans_o), 2);
            chk({tag, ":a_hsel"}, 32'(hsel_o), 1);
            chk({tag, ":a_haddr"}, haddr_o, addr);
            chk({tag, ":a_hwrite"}, 32'(hwrite_o), 32'(wr));
            chk({tag, ":a_ready"}, 32'(req_ready_o), 0);
            slv_idx = haddr_o[11:2];
            step();
            for (int i = 0; i < waits; i++) begin
                hready_i = 1'b0;
                hresp_i  = (slv_err && (i == waits - 1)) ? 2'b01 : 2'b00;
                @(negedge clk_i);
                chk({tag, ":w_htrans"}, 32'(htrans_o), 0);
                chk({tag, ":w_rsp_valid"}, 32'(rsp_valid_o), 0);
                if (wr) chk({tag, ":w_hwdata"}, hwdata_o, wdata);
                step();
            end
            hready_i = 1'b1;
            hresp_i  = slv_err ? 2'b01 : 2'b00;
            hrdata_i = wr ? $urandom : slave_mem[slv_idx];
            @(negedge clk_i);
            chk({tag, ":d_htrans"}, 32'(htrans_o), 0);
            chk({tag, ":d_hsel"}, 32'(hsel_o), 0);
            if (wr) chk({tag, ":d_hwdata"}, hwdata_o, wdata);
            if (wr && !slv_err) slave_mem[slv_idx] = hwdata_o;
            step();
            hresp_i   = 2'b00;
            hrdata_i  = $urandom;
            exp_err   = slv_err;
            exp_rdata = (wr || slv_err) ? 32'h0 : ref_mem[idx];
            if (wr && !slv_err) ref_mem[idx] = wdata;
        end
        rsp_ready_i = (bp == 0);
        if (bp > 0) begin
            req_valid_i = 1'b1;
            req_write_i = 1'b0;
            req_addr_i  = 32'h80100000;
        end
        @(negedge clk_i);
        chk({tag, ":rsp_valid"}, 32'(rsp_valid_o), 1);
        chk({tag, ":rsp_err"}, 32'(rsp_err_o), 32'(exp_err));
        chk({tag, ":rsp_tmo"}, 32'(rsp_timeout_o), 0);
        chk({tag, ":rsp_rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, ":rsp_hsel"}, 32'(hsel_o), 0);
        chk({tag, ":rsp_ready"}, 32'(req_ready_o), 0);
        for (int i = 1; i <= bp; i++) begin
            step();
            rsp_ready_i = (i == bp);
            @(negedge clk_i);
            chk({tag, ":bp_valid"}, 32'(rsp_valid_o), 1);
            chk({tag, ":bp_err"}, 32'(rsp_err_o), 32'(exp_err));
            chk({tag, ":bp_rdata"}, rsp_rdata_o, exp_rdata);
            chk({tag, ":bp_ready"}, 32'(req_ready_o), 0);
        end
        step();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk({tag, ":end_valid"}, 32'(rsp_valid_o), 0);
        chk({tag, ":end_ready"}, 32'(req_ready_o), 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [9:0]  ridx;
        logic        rwr;
        n_vec       = 0;
        n_miscmp    = 0;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 32'h0;
        req_wdata_i = 32'h0;
        rsp_ready_i = 1'b0;
        hready_i    = 1'b1;
        hresp_i     = 2'b00;
        hrdata_i    = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]   = 32'h0;
            slave_mem[i] = 32'h0;
        end
        ref_mem[1]   = 32'h12345678;
        slave_mem[1] = 32'h12345678;

        step();
        step();
        @(negedge clk_i);
        chk("rst:hsel", 32'(hsel_o), 0);
        chk("rst:htrans", 32'(htrans_o), 0);
        chk("rst:haddr", haddr_o, 0);
        chk("rst:hwdata", hwdata_o, 0);
        chk("rst:rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst:hsize", 32'(hsize_o), 2);
        chk("rst:hburst", 32'(hburst_o), 0);
        chk("rst:hprot", 32'(hprot_o), 3);
        chk("rst:hmastlock", 32'(hmastlock_o), 0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst:req_ready", 32'(req_ready_o), 1);

        run_xfer("wr0",      1'b1, 32'h801000ac, 32'hcafecafe, 0, 1'b0, 0);
        run_xfer("rd_wait3", 1'b0, 32'h80100004, 32'h0,        3, 1'b0, 0);
        run_xfer("rd_ac",    1'b0, 32'h801000ac, 32'h0,        0, 1'b0, 0);
        run_xfer("dec_win",  1'b0, 32'h80200000, 32'h0,        0, 1'b0, 0);
        run_xfer("dec_algn", 1'b1, 32'h80100002, 32'h11111111, 0, 1'b0, 0);
        run_xfer("slv_err",  1'b0, 32'h80100004, 32'h0,        1, 1'b1, 0);
        run_xfer("bp5",      1'b0, 32'h801000ac, 32'h0,        0, 1'b0, 5);

        // Stuck slave: four address-phase stalls, then a timeout response
        step();
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h80100010;
        hready_i    = 1'b0;
        @(negedge clk_i);
        chk("tmo:acc_ready", 32'(req_ready_o), 1);
        step();
        req_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            chk("tmo:stall_htrans", 32'(htrans_o), 2);
            chk("tmo:stall_valid", 32'(rsp_valid_o), 0);
            step();
        end
        hready_i = 1'b1;
        hrdata_i = 32'hdeadbeef;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("tmo:htrans", 32'(htrans_o), 0);
            chk("tmo:hsel", 32'(hsel_o), 0);
            chk("tmo:rsp_valid", 32'(rsp_valid_o), 1);
            chk("tmo:rsp_err", 32'(rsp_err_o), 1);
            chk("tmo:rsp_tmo", 32'(rsp_timeout_o), 1);
            chk("tmo:rsp_rdata", rsp_rdata_o, 0);
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        chk("tmo:end_ready", 32'(req_ready_o), 1);
        chk("tmo:end_htrans", 32'(htrans_o), 0);

        for (int n = 0; n < 200; n++) begin
            ridx  = 10'($urandom_range(0, 1023));
            rwr   = 1'($urandom_range(0, 1));
            a     = 32'h80100000;
            a[11:2] = ridx;
            run_xfer(rwr ? "rnd_wr" : "rnd_rd", rwr, a, $urandom,
                     int'($urandom_range(0, 2)), 1'b0, int'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stalled write data phase
        step();
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h80100020;
        req_wdata_i = 32'h55aa55aa;
        step();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mrst:addr_hsel", 32'(hsel_o), 1);
        step();
        hready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("mrst:hsel", 32'(hsel_o), 0);
        chk("mrst:htrans", 32'(htrans_o), 0);
        chk("mrst:hwrite", 32'(hwrite_o), 0);
        chk("mrst:haddr", haddr_o, 0);
        chk("mrst:hwdata", hwdata_o, 0);
        chk("mrst:rsp_valid", 32'(rsp_valid_o), 0);
        chk("mrst:rsp_rdata", rsp_rdata_o, 0);
        chk("mrst:rsp_err", 32'(rsp_err_o), 0);
        chk("mrst:rsp_tmo", 32'(rsp_timeout_o), 0);
        step();
        rst_i    = 1'b0;
        hready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("mrst:req_ready", 32'(req_ready_o), 1);
            chk("mrst:no_rsp", 32'(rsp_valid_o), 0);
            chk("mrst:no_hsel", 32'(hsel_o), 0);
            step();
        end
        run_xfer("post_rst", 1'b0, 32'h80100020, 32'h0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
